// File: rtl/io_stream_feeder_pkg.sv
// Shared types and constants for the host-side A/B stream feeder.
package io_stream_feeder_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } feeder_state_e;

  typedef enum logic {
    STREAM_A,
    STREAM_B
  } stream_id_e;

  localparam int unsigned FEEDER_FIFO_DEPTH = 4;
  localparam int unsigned FEEDER_OCC_W      = $clog2(FEEDER_FIFO_DEPTH + 1);
  localparam int unsigned FEEDER_PTR_W      = $clog2(FEEDER_FIFO_DEPTH);

  // Outstanding source read: which stream the returning word belongs to
  typedef struct packed {
    logic       valid;
    stream_id_e id;
  } read_tag_t;

endpackage

// File: rtl/io_stream_feeder_if.sv
// Source-memory read port plus the A and B valid/ready streams toward top_chip.
interface io_stream_feeder_if #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned ADDR_W = 12
);

  logic [DATA_W-1:0] a_input;
  logic              a_valid;
  logic              a_ready;
  logic [DATA_W-1:0] b_input;
  logic              b_valid;
  logic              b_ready;
  logic [ADDR_W-1:0] src_read_addr;
  logic              src_read_en;
  logic [DATA_W-1:0] src_qout;

  modport master (
    output a_input, a_valid, b_input, b_valid, src_read_addr, src_read_en,
    input  a_ready, b_ready, src_qout
  );

  modport slave (
    input  a_input, a_valid, b_input, b_valid, src_read_addr, src_read_en,
    output a_ready, b_ready, src_qout
  );

endinterface

// File: rtl/io_stream_feeder_fifo.sv
// Depth-4 register FIFO; head reads as zero while empty.
module stream_fifo
  import io_stream_feeder_pkg::*;
#(
  parameter int unsigned WIDTH = 16
) (
  input  logic                    clk,
  input  logic                    rst_in,
  input  logic                    push,
  input  logic                    pop,
  input  logic [WIDTH-1:0]        data,
  output logic [WIDTH-1:0]        head,
  output logic                    empty,
  output logic [FEEDER_OCC_W-1:0] occ
);

  logic [WIDTH-1:0]        mem [FEEDER_FIFO_DEPTH];
  logic [FEEDER_PTR_W-1:0] rd_ptr;
  logic [FEEDER_PTR_W-1:0] wr_ptr;
  logic                    do_pop;

  assign empty  = (occ == '0);
  assign do_pop = pop && !empty;
  assign head   = empty ? '0 : mem[rd_ptr];

  // Storage carries no reset; only the pointers define what is live
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst_in) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      occ    <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + FEEDER_PTR_W'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + FEEDER_PTR_W'(1);
      end
      occ <= occ + FEEDER_OCC_W'(push) - FEEDER_OCC_W'(do_pop);
    end
  end

  // The issuer's credit check must make a push into a full FIFO impossible
  a_no_overflow: assert property (@(posedge clk) disable iff (rst_in)
    !(push && occ == FEEDER_OCC_W'(FEEDER_FIFO_DEPTH)));

endmodule

// File: rtl/io_stream_feeder.sv
// Shares one source-memory read port round-robin between the A and B streams,
// each backed by a small FIFO so a lone stream still sustains one word per cycle.
module io_stream_feeder
  import io_stream_feeder_pkg::*;
#(
  parameter int unsigned  IO_DATA_WIDTH  = 16,
  parameter int unsigned  SRC_MEM_HEIGHT = 1 << 12,
  localparam int unsigned AW             = $clog2(SRC_MEM_HEIGHT),
  localparam int unsigned LW             = AW + 1
) (
  input  logic                 clk,
  input  logic                 rst_in,
  input  logic                 start,
  input  logic [AW-1:0]        a_base,
  input  logic [AW-1:0]        b_base,
  input  logic [LW-1:0]        a_len,
  input  logic [LW-1:0]        b_len,
  output logic                 busy,
  output logic                 done,
  io_stream_feeder_if.master   bus
);

  feeder_state_e           state_q, state_d;
  stream_id_e              ptr_q, ptr_d;
  read_tag_t               tag_q;
  logic [AW-1:0]           addr_a_q, addr_b_q;
  logic [LW-1:0]           rem_a_q, rem_b_q;

  logic [FEEDER_OCC_W-1:0] occ_a, occ_b;
  logic [FEEDER_OCC_W-1:0] credit_a, credit_b;
  logic                    empty_a, empty_b;
  logic [IO_DATA_WIDTH-1:0] head_a, head_b;
  logic                    inflight_a, inflight_b;
  logic                    pop_a, pop_b;
  logic                    elig_a, elig_b;
  logic                    grant_a, grant_b;
  logic                    drain_a, drain_b;

  assign inflight_a = tag_q.valid && (tag_q.id == STREAM_A);
  assign inflight_b = tag_q.valid && (tag_q.id == STREAM_B);
  assign credit_a   = occ_a + FEEDER_OCC_W'(inflight_a);
  assign credit_b   = occ_b + FEEDER_OCC_W'(inflight_b);
  assign elig_a     = (state_q == RUN) && (rem_a_q != '0) &&
                      (credit_a < FEEDER_OCC_W'(FEEDER_FIFO_DEPTH));
  assign elig_b     = (state_q == RUN) && (rem_b_q != '0) &&
                      (credit_b < FEEDER_OCC_W'(FEEDER_FIFO_DEPTH));

  assign pop_a   = bus.a_valid && bus.a_ready;
  assign pop_b   = bus.b_valid && bus.b_ready;
  // A FIFO counts as drained if it is empty or its last word leaves this cycle
  assign drain_a = (occ_a == '0) || ((occ_a == FEEDER_OCC_W'(1)) && pop_a);
  assign drain_b = (occ_b == '0) || ((occ_b == FEEDER_OCC_W'(1)) && pop_b);

  assign busy        = (state_q != IDLE);
  assign done        = (state_q == DONE);
  assign bus.a_valid = !empty_a;
  assign bus.b_valid = !empty_b;
  assign bus.a_input = head_a;
  assign bus.b_input = head_b;

  always_ff @(posedge clk) begin
    if (rst_in) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Arbitration, read issue and next-state
  always_comb begin
    state_d           = state_q;
    ptr_d             = ptr_q;
    grant_a           = 1'b0;
    grant_b           = 1'b0;
    bus.src_read_en   = 1'b0;
    bus.src_read_addr = '0;

    if (elig_a && elig_b) begin
      grant_a = (ptr_q == STREAM_A);
      grant_b = (ptr_q == STREAM_B);
      ptr_d   = (ptr_q == STREAM_A) ? STREAM_B : STREAM_A;
    end else begin
      grant_a = elig_a;
      grant_b = elig_b;
    end

    if (grant_a) begin
      bus.src_read_en   = 1'b1;
      bus.src_read_addr = addr_a_q;
    end else if (grant_b) begin
      bus.src_read_en   = 1'b1;
      bus.src_read_addr = addr_b_q;
    end

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = RUN;
        end
      end
      RUN: begin
        if ((rem_a_q == '0) && (rem_b_q == '0) && !tag_q.valid && drain_a && drain_b) begin
          state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst_in) begin
      ptr_q       <= STREAM_A;
      tag_q.valid <= 1'b0;
      tag_q.id    <= STREAM_A;
      addr_a_q    <= '0;
      addr_b_q    <= '0;
      rem_a_q     <= '0;
      rem_b_q     <= '0;
    end else begin
      ptr_q       <= ptr_d;
      tag_q.valid <= grant_a || grant_b;
      tag_q.id    <= grant_b ? STREAM_B : STREAM_A;
      if ((state_q == IDLE) && start) begin
        addr_a_q <= a_base;
        addr_b_q <= b_base;
        rem_a_q  <= a_len;
        rem_b_q  <= b_len;
      end
      // Address wraps naturally at the memory depth
      if (grant_a) begin
        addr_a_q <= addr_a_q + AW'(1);
        rem_a_q  <= rem_a_q - LW'(1);
      end
      if (grant_b) begin
        addr_b_q <= addr_b_q + AW'(1);
        rem_b_q  <= rem_b_q - LW'(1);
      end
    end
  end

  stream_fifo #(.WIDTH(IO_DATA_WIDTH)) u_fifo_a (
    .clk    (clk),
    .rst_in (rst_in),
    .push   (inflight_a),
    .pop    (pop_a),
    .data   (bus.src_qout),
    .head   (head_a),
    .empty  (empty_a),
    .occ    (occ_a)
  );

  stream_fifo #(.WIDTH(IO_DATA_WIDTH)) u_fifo_b (
    .clk    (clk),
    .rst_in (rst_in),
    .push   (inflight_b),
    .pop    (pop_b),
    .data   (bus.src_qout),
    .head   (head_b),
    .empty  (empty_b),
    .occ    (occ_b)
  );

endmodule

// File: tb/tb_io_stream_feeder.sv
// Directed plus randomized bench for io_stream_feeder against a memory/queue reference model.
module tb_io_stream_feeder;

  localparam int unsigned DW = 16;
  localparam int unsigned H  = 4096;
  localparam int unsigned AW = 12;
  localparam int unsigned LW = AW + 1;

  logic          clk;
  logic          rst_in;
  logic          start;
  logic [AW-1:0] a_base, b_base;
  logic [LW-1:0] a_len, b_len;
  logic          busy, done;

  io_stream_feeder_if #(.DATA_W(DW), .ADDR_W(AW)) bus ();

  io_stream_feeder #(.IO_DATA_WIDTH(DW), .SRC_MEM_HEIGHT(H)) dut (
    .clk    (clk),
    .rst_in (rst_in),
    .start  (start),
    .a_base (a_base),
    .b_base (b_base),
    .a_len  (a_len),
    .b_len  (b_len),
    .busy   (busy),
    .done   (done),
    .bus    (bus)
  );

  logic [DW-1:0] mem [H];
  int            cyc = 0;
  int            t0;
  int            checks;
  int            failures;
  int            rd_addr[$];
  logic [DW-1:0] a_dat[$];
  logic [DW-1:0] b_dat[$];
  int            a_cyc[$];
  int            b_valid_cnt;
  bit            rand_ready;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Source memory with one-cycle read latency
  always @(posedge clk) begin
    if (bus.src_read_en === 1'b1) bus.src_qout <= mem[bus.src_read_addr];
  end

  // Passive logger of reads and completed handshakes
  always @(negedge clk) begin
    if (bus.src_read_en === 1'b1) rd_addr.push_back(int'(bus.src_read_addr));
    if (bus.a_valid === 1'b1 && bus.a_ready === 1'b1) begin
      a_dat.push_back(bus.a_input);
      a_cyc.push_back(cyc);
    end
    if (bus.b_valid === 1'b1 && bus.b_ready === 1'b1) b_dat.push_back(bus.b_input);
    if (bus.b_valid === 1'b1) b_valid_cnt++;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "bench timeout");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_logs();
    rd_addr.delete();
    a_dat.delete();
    b_dat.delete();
    a_cyc.delete();
    b_valid_cnt = 0;
  endtask

  task automatic fill_random();
    for (int i = 0; i < int'(H); i++) mem[i] = DW'($urandom);
  endtask

  // Pulse start for one cycle; returns at the start of relative cycle 1
  task automatic launch(input int ab, input int bb, input int al, input int bl);
    clear_logs();
    step();
    start  = 1'b1;
    a_base = AW'(ab);
    b_base = AW'(bb);
    a_len  = LW'(al);
    b_len  = LW'(bl);
    t0     = cyc;
    step();
    start  = 1'b0;
  endtask

  task automatic wait_done(input int budget, output int rel);
    rel = -1;
    for (int i = 0; i < budget; i++) begin
      step();
      if (rand_ready) begin
        bus.a_ready = ($urandom_range(0, 3) != 0);
        bus.b_ready = ($urandom_range(0, 3) != 0);
      end
      @(negedge clk);
      if (done === 1'b1) begin
        rel = cyc - t0;
        break;
      end
    end
    chk("done_seen", 32'(rel >= 0), 1);
    @(negedge clk);
    chk("busy_after_done", 32'(busy), 0);
  endtask

  // Reference: stream X must deliver mem[(base+i) mod H] for i < len, in order
  task automatic check_stream(input string tag, input logic [DW-1:0] got[$], input int base, input int len);
    int bad;
    bad = 0;
    chk({tag, "_count"}, got.size(), len);
    for (int i = 0; i < len && i < got.size(); i++) begin
      if (got[i] !== mem[(base + i) % int'(H)]) bad++;
    end
    chk({tag, "_data"}, bad, 0);
  endtask

  initial begin
    int rel;
    int bad;
    int base;
    int ab, bb, al, bl;
    int exp_rd[$];

    checks      = 0;
    failures    = 0;
    rst_in      = 1'b1;
    start       = 1'b0;
    a_base      = '0;
    b_base      = '0;
    a_len       = '0;
    b_len       = '0;
    bus.a_ready = 1'b0;
    bus.b_ready = 1'b0;
    rand_ready  = 1'b0;
    b_valid_cnt = 0;
    for (int i = 0; i < int'(H); i++) mem[i] = DW'(i);

    repeat (3) step();
    rst_in = 1'b0;
    @(negedge clk);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_read_en", 32'(bus.src_read_en), 0);
    chk("rst_read_addr", 32'(bus.src_read_addr), 0);
    chk("rst_a_valid", 32'(bus.a_valid), 0);
    chk("rst_b_valid", 32'(bus.b_valid), 0);
    chk("rst_a_input", 32'(bus.a_input), 0);
    chk("rst_b_input", 32'(bus.b_input), 0);

    // Basic A-only stream with identity memory
    bus.a_ready = 1'b1;
    bus.b_ready = 1'b1;
    launch(16'h010, 0, 4, 0);
    @(negedge clk);
    chk("basic_busy_c1", 32'(busy), 1);
    chk("basic_read_en_c1", 32'(bus.src_read_en), 1);
    chk("basic_read_addr_c1", 32'(bus.src_read_addr), 32'h010);
    wait_done(50, rel);
    chk("basic_done_cycle", rel, 7);
    check_stream("basic_a", a_dat, 16'h010, 4);
    chk("basic_a_first", 32'(a_dat.size() > 0 ? a_dat[0] : 16'hdead), 32'h0010);
    bad = 0;
    for (int i = 0; i < a_cyc.size(); i++) if (a_cyc[i] - t0 != 3 + i) bad++;
    chk("basic_a_cycles", bad, 0);
    chk("basic_b_never_valid", b_valid_cnt, 0);

    // Interleave: both streams active, reads alternate starting with A
    fill_random();
    launch(0, 16'h100, 3, 3);
    wait_done(60, rel);
    exp_rd.delete();
    for (int i = 0; i < 3; i++) begin
      exp_rd.push_back(i);
      exp_rd.push_back(16'h100 + i);
    end
    chk("ilv_read_count", rd_addr.size(), 6);
    bad = 0;
    for (int i = 0; i < 6 && i < rd_addr.size(); i++) if (rd_addr[i] != exp_rd[i]) bad++;
    chk("ilv_read_order", bad, 0);
    check_stream("ilv_a", a_dat, 0, 3);
    check_stream("ilv_b", b_dat, 16'h100, 3);
    chk("ilv_done_cycle", rel, 9);

    // Backpressure: A stalled for 10 cycles after its first valid
    bus.a_ready = 1'b0;
    base = $urandom_range(0, H - 1);
    launch(base, 0, 10, 0);
    bad = 0;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      if (k >= 3 && (bus.a_valid !== 1'b1 || bus.a_input !== mem[base])) bad++;
      if (k < 12) step();
    end
    chk("bp_head_stable", bad, 0);
    chk("bp_reads_while_stalled", rd_addr.size(), 4);
    chk("bp_no_pop_while_stalled", a_dat.size(), 0);
    step();
    bus.a_ready = 1'b1;
    wait_done(80, rel);
    check_stream("bp_a", a_dat, base, 10);

    // Address wrap past the top of memory
    launch(H - 2, 0, 4, 0);
    wait_done(50, rel);
    bad = 0;
    chk("wrap_read_count", rd_addr.size(), 4);
    for (int i = 0; i < 4 && i < rd_addr.size(); i++) if (rd_addr[i] != (int'(H) - 2 + i) % int'(H)) bad++;
    chk("wrap_read_addrs", bad, 0);
    check_stream("wrap_a", a_dat, H - 2, 4);

    // Both lengths zero
    launch($urandom_range(0, H - 1), $urandom_range(0, H - 1), 0, 0);
    wait_done(20, rel);
    chk("zero_done_cycle", rel, 2);
    chk("zero_reads", rd_addr.size(), 0);
    chk("zero_a_words", a_dat.size(), 0);

    // A second start during RUN must be ignored
    base = $urandom_range(0, H - 1);
    launch(base, 0, 5, 0);
    step();
    step();
    start  = 1'b1;
    a_base = AW'(base + 100);
    a_len  = LW'(9);
    b_len  = LW'(3);
    step();
    start  = 1'b0;
    wait_done(60, rel);
    chk("ign_done_cycle", rel, 8);
    check_stream("ign_a", a_dat, base, 5);
    chk("ign_b_never_valid", b_valid_cnt, 0);
    repeat (4) @(negedge clk);
    chk("ign_no_extra_reads", rd_addr.size(), 5);

    // Reset mid-run with two words buffered and a read in flight
    bus.a_ready = 1'b0;
    base = $urandom_range(0, H - 1);
    launch(base, 0, 8, 0);
    step();
    step();
    step();
    rst_in = 1'b1;
    @(negedge clk);
    chk("mrst_pre_a_valid", 32'(bus.a_valid), 1);
    chk("mrst_pre_read_en", 32'(bus.src_read_en), 1);
    step();
    rst_in = 1'b0;
    @(negedge clk);
    chk("mrst_busy", 32'(busy), 0);
    chk("mrst_read_en", 32'(bus.src_read_en), 0);
    chk("mrst_a_valid", 32'(bus.a_valid), 0);
    chk("mrst_b_valid", 32'(bus.b_valid), 0);
    step();
    @(negedge clk);
    chk("mrst_inflight_dropped", 32'(bus.a_valid), 0);
    bus.a_ready = 1'b1;
    launch(base, 0, 8, 0);
    wait_done(80, rel);
    check_stream("mrst_replay_a", a_dat, base, 8);

    // Randomized runs with random backpressure against the reference model
    rand_ready = 1'b1;
    for (int r = 0; r < 8; r++) begin
      fill_random();
      ab = $urandom_range(0, H - 1);
      bb = $urandom_range(0, H - 1);
      al = $urandom_range(0, 12);
      bl = $urandom_range(0, 12);
      launch(ab, bb, al, bl);
      wait_done(600, rel);
      check_stream("rand_a", a_dat, ab, al);
      check_stream("rand_b", b_dat, bb, bl);
      chk("rand_read_total", rd_addr.size(), al + bl);
    end
    rand_ready  = 1'b0;
    bus.a_ready = 1'b1;
    bus.b_ready = 1'b1;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/io_stream_feeder.md
# io_stream_feeder

Host-side transmitter for the accelerator's activation/weight input streams: it reads words from a single-read-port source memory and drives the `a_input`/`a_valid`/`a_ready` and `b_input`/`b_valid`/`b_ready` handshakes that `top_chip` receives. One memory port is shared round-robin between the A and B streams, each backed by a 4-entry buffer, so either stream can sustain one word per cycle. It sits beside the chip, outside the bandwidth boundary, and replaces ad-hoc testbench drivers.

## Interface
- `IO_DATA_WIDTH`, 16, stream word width
- `SRC_MEM_HEIGHT`, 1<<12, source memory depth in words; `AW = $clog2(SRC_MEM_HEIGHT)`
- `clk` in 1: single clock, rising edge
- `rst_in` in 1: reset, synchronous, active-high
- `start` in 1: one-cycle pulse; sampled only in IDLE
- `a_base`, `b_base` in AW: first source address per stream, sampled with `start`
- `a_len`, `b_len` in AW+1: word count per stream, 0 allowed, sampled with `start`
- `busy` out 1: high in RUN
- `done` out 1: one-cycle pulse when both streams are fully delivered
- `src_read_addr` out AW: source memory read address
- `src_read_en` out 1: read strobe; data returns on `src_qout` the following cycle
- `src_qout` in IO_DATA_WIDTH: source read data
- `a_input` out IO_DATA_WIDTH, `a_valid` out 1, `a_ready` in 1: A stream
- `b_input` out IO_DATA_WIDTH, `b_valid` out 1, `b_ready` in 1: B stream

## Operation
- States: IDLE -> RUN on `start`; RUN -> DONE when both issue counters reach len, both FIFOs are empty, and no read is in flight; DONE -> IDLE unconditionally. `done` is high only in DONE.
- On `start`: latch next-address and remaining-count registers per stream. `start` outside IDLE is ignored.
- Eligibility of stream X: remaining > 0 and occ_X + inflight_X < 4. Both terms are registered, so `src_read_en` never depends combinationally on `a_ready`/`b_ready`.
- Arbiter: if only one stream is eligible, grant it. If both are, grant the stream selected by a priority pointer, then toggle the pointer. The pointer resets to A.
- On a grant: `src_read_en`=1, `src_read_addr`=next address of the granted stream, next address +1, remaining -1. A 1-bit tag plus valid is registered; the next cycle `src_qout` is pushed into the tagged FIFO.
- Stream output: `x_valid` = FIFO not empty, `x_input` = FIFO head. Pop on `x_valid & x_ready`. Once `x_valid` is high, valid and data hold until the handshake.
- Address arithmetic is modulo SRC_MEM_HEIGHT (wrap past the top, no error).
- Length 0: that stream is complete immediately and never asserts valid. Both lengths 0: RUN lasts one cycle, then DONE.

## Timing
- Reset values: `busy`, `done`, `src_read_en`, `a_valid`, `b_valid` = 0; `src_read_addr`, `a_input`, `b_input` = 0; FIFOs empty, in-flight cleared, pointer = A, state IDLE.
- `start` in cycle 0 -> `busy`=1 and first `src_read_en` in cycle 1 -> `src_qout` in cycle 2 -> `x_valid` in cycle 3.
- Last handshake in cycle n -> `done` in cycle n+1 -> `busy`=0 and IDLE in cycle n+2.
- Throughput with ready held high: a single active stream delivers 1 word/cycle; two active streams deliver 1 word/cycle total, alternating.
- Push and pop on the same FIFO in the same cycle are legal and leave occ unchanged. A push is guaranteed never to hit a full FIFO by the credit rule; an assertion must check this.
- Reset mid-operation: all state clears in the next cycle, and a read data return in flight is discarded.

## Structure
- Package `io_stream_feeder_pkg` holds:
  - `feeder_state_e` (IDLE, RUN, DONE)
  - `stream_id_e` (STREAM_A, STREAM_B)
  - `FEEDER_FIFO_DEPTH` = 4
- Sub-module `stream_fifo`: depth-4 register FIFO with push/pop/head/empty, plus an `occ` count output. Instantiate it twice.

## Test plan
- Basic A only: `a_base`=0x010, `a_len`=4, `b_len`=0, ready=1, memory[i]=i -> `a_input` 0x10..0x13 on cycles 3..6, `done` in cycle 7, `b_valid` never high.
- Interleave: both len 3, bases 0x000/0x100, ready=1 -> reads alternate A,B,A,B,A,B starting with A; each stream receives its words in order.
- Backpressure: `a_ready` low for 10 cycles after the first valid -> at most 4 reads issued for A, `a_input` stable while stalled, no word lost or duplicated after release.
- Wrap: `a_base`=SRC_MEM_HEIGHT-2, `a_len`=4 -> read addresses max-1, max, 0, 1.
- Zero length and ignored start: both lengths 0 -> `done` in cycle 2. A second `start` during RUN changes nothing.
- Reset mid-run: assert `rst_in` with 2 words buffered and a read in flight -> next cycle all valids, `busy` and `src_read_en` are 0; a new `start` replays from the base address cleanly.
